// File: rtl/c17_bist_pkg.sv
// Shared types and defaults for the c17 response compactor.
// Optional build macro: C17_RESP_XMASK_EN (adds a response-mask input).
package c17_bist_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPACT = 2'd1,
      CHECK   = 2'd2,
      FIN     = 2'd3
   } state_e;

   localparam int          DEF_RESP_W = 8;
   localparam int          DEF_SIG_W  = 16;
   localparam int          DEF_CNT_W  = 16;
   localparam logic [15:0] DEF_POLY   = 16'h1021;
   localparam logic [15:0] DEF_SEED   = 16'h0000;

   // Bit positions of each c17 instance's outputs within resp_data.
   localparam int P1_N22 = 0;
   localparam int P1_N23 = 1;
   localparam int P2_N22 = 2;
   localparam int P2_N23 = 3;
   localparam int P3_N22 = 4;
   localparam int P3_N23 = 5;
   localparam int P4_N22 = 6;
   localparam int P4_N23 = 7;

endpackage

// File: rtl/c17_misr.sv
// Multiple-input signature register: shift with polynomial feedback and XOR in data.
// Load takes priority over the shift enable.
module c17_misr #(
   parameter int               RESP_W = 8,
   parameter int               SIG_W  = 16,
   parameter logic [SIG_W-1:0] POLY   = 16'h1021
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [SIG_W-1:0]  seed,
   input  logic              enable,
   input  logic [RESP_W-1:0] data,
   output logic [SIG_W-1:0]  sig
);

   logic [SIG_W-1:0] sig_q;
   logic [SIG_W-1:0] sig_d;

   always_comb begin
      sig_d = sig_q;
      if (load) begin
         sig_d = seed;
      end else if (enable) begin
         sig_d = {sig_q[SIG_W-2:0], 1'b0}
               ^ (sig_q[SIG_W-1] ? POLY : '0)
               ^ SIG_W'(data);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/c17_resp_misr.sv
// Response compactor for the quad c17 core: run FSM, pattern counter and golden compare.
// Optional build macro: C17_RESP_XMASK_EN adds resp_xmask to blank unstable response bits.
module c17_resp_misr
   import c17_bist_pkg::*;
#(
   parameter int               RESP_W = DEF_RESP_W,
   parameter int               SIG_W  = DEF_SIG_W,
   parameter logic [SIG_W-1:0] POLY   = DEF_POLY,
   parameter logic [SIG_W-1:0] SEED   = DEF_SEED,
   parameter int               CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_patterns,
   input  logic [SIG_W-1:0]  golden_sig,
   input  logic              resp_valid,
   input  logic [RESP_W-1:0] resp_data,
`ifdef C17_RESP_XMASK_EN
   input  logic [RESP_W-1:0] resp_xmask,
`endif
   output logic              resp_ready,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [SIG_W-1:0]  signature,
   output logic [CNT_W-1:0]  patterns_seen
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] seen_q, seen_d;
   logic [CNT_W-1:0] target_q, target_d;
   logic [SIG_W-1:0] golden_q, golden_d;
   logic             pass_q, pass_d;
   logic             handshake;
   logic             misr_load;
   logic [RESP_W-1:0] resp_masked;
   logic [SIG_W-1:0] sig;

`ifdef C17_RESP_XMASK_EN
   assign resp_masked = resp_data & ~resp_xmask;
`else
   assign resp_masked = resp_data;
`endif

   assign handshake = (state_q == COMPACT) && resp_valid;

   // Leaving COMPACT on the final accept is what keeps patterns_seen from ever wrapping.
   always_comb begin
      state_d   = state_q;
      seen_d    = seen_q;
      target_d  = target_q;
      golden_d  = golden_q;
      pass_d    = pass_q;
      misr_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               misr_load = 1'b1;
               seen_d    = '0;
               pass_d    = 1'b0;
               target_d  = num_patterns;
               golden_d  = golden_sig;
               state_d   = (num_patterns == '0) ? CHECK : COMPACT;
            end
         end
         COMPACT: begin
            if (handshake) begin
               seen_d = seen_q + CNT_W'(1);
               if (seen_q + CNT_W'(1) == target_q) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            pass_d  = (sig == golden_q);
            state_d = FIN;
         end
         FIN: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         seen_q   <= '0;
         target_q <= '0;
         golden_q <= '0;
         pass_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         seen_q   <= seen_d;
         target_q <= target_d;
         golden_q <= golden_d;
         pass_q   <= pass_d;
      end
   end

   c17_misr #(
      .RESP_W (RESP_W),
      .SIG_W  (SIG_W),
      .POLY   (POLY)
   ) u_misr (
      .clk    (clk),
      .rst    (rst),
      .load   (misr_load),
      .seed   (SEED),
      .enable (handshake),
      .data   (resp_masked),
      .sig    (sig)
   );

   assign resp_ready    = (state_q == COMPACT);
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == FIN);
   assign pass          = pass_q;
   assign signature     = sig;
   assign patterns_seen = seen_q;

endmodule

// File: tb/tb_c17_resp_misr.sv
// Directed self-checking bench for c17_resp_misr with hand-computed signatures.
// Define C17_RESP_XMASK_EN to also exercise the response mask.
module tb_c17_resp_misr;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] num_patterns;
   logic [15:0] golden_sig;
   logic        resp_valid;
   logic [7:0]  resp_data;
   logic [7:0]  resp_xmask;
   logic        resp_ready;
   logic        busy;
   logic        done;
   logic        pass;
   logic [15:0] signature;
   logic [15:0] patterns_seen;

   int checks = 0;
   int errors = 0;

   c17_resp_misr dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .num_patterns  (num_patterns),
      .golden_sig    (golden_sig),
      .resp_valid    (resp_valid),
      .resp_data     (resp_data),
`ifdef C17_RESP_XMASK_EN
      .resp_xmask    (resp_xmask),
`endif
      .resp_ready    (resp_ready),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .signature     (signature),
      .patterns_seen (patterns_seen)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic start_run(input logic [15:0] n, input logic [15:0] g);
      start        = 1'b1;
      num_patterns = n;
      golden_sig   = g;
      tick();
      start        = 1'b0;
      num_patterns = 16'hFFFF;
      golden_sig   = 16'hDEAD;
   endtask

   task automatic send(input logic [7:0] d);
      resp_valid = 1'b1;
      resp_data  = d;
      tick();
      resp_valid = 1'b0;
      resp_data  = 8'hA5;
   endtask

   // Called right after the edge that accepted the final response (state CHECK).
   task automatic finish_run(input string tag, input logic exp_pass,
                             input logic [15:0] exp_sig, input logic [15:0] exp_seen);
      check_output({tag, "_check_ready"}, 32'(resp_ready), 32'd0);
      check_output({tag, "_check_done"}, 32'(done), 32'd0);
      tick();
      check_output({tag, "_fin_done"}, 32'(done), 32'd1);
      check_output({tag, "_fin_busy"}, 32'(busy), 32'd1);
      check_output({tag, "_fin_pass"}, 32'(pass), 32'(exp_pass));
      tick();
      check_output({tag, "_idle_done"}, 32'(done), 32'd0);
      check_output({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check_output({tag, "_hold_pass"}, 32'(pass), 32'(exp_pass));
      check_output({tag, "_hold_sig"}, 32'(signature), 32'(exp_sig));
      check_output({tag, "_hold_seen"}, 32'(patterns_seen), 32'(exp_seen));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; num_patterns = '0; golden_sig = '0;
      resp_valid = 1'b0; resp_data = '0; resp_xmask = '0;
      @(negedge clk);
      check_output("rst_ready", 32'(resp_ready), 32'd0);
      check_output("rst_busy", 32'(busy), 32'd0);
      check_output("rst_done", 32'(done), 32'd0);
      check_output("rst_pass", 32'(pass), 32'd0);
      check_output("rst_sig", 32'(signature), 32'd0);
      check_output("rst_seen", 32'(patterns_seen), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Basic pass: 0003 then (0003<<1)^000F = 0009.
      start_run(16'd2, 16'h0009);
      check_output("basic_ready", 32'(resp_ready), 32'd1);
      check_output("basic_busy", 32'(busy), 32'd1);
      send(8'h03);
      check_output("basic_sig1", 32'(signature), 32'h0003);
      check_output("basic_seen1", 32'(patterns_seen), 32'd1);
      send(8'h0F);
      check_output("basic_sig2", 32'(signature), 32'h0009);
      finish_run("basic", 1'b1, 16'h0009, 16'd2);

      // Mismatch against golden 0008.
      start_run(16'd2, 16'h0008);
      send(8'h03);
      send(8'h0F);
      finish_run("mism", 1'b0, 16'h0009, 16'd2);

      // Feedback tap: 0x80 shifted 8 times reaches 8000, one more shift yields POLY.
      start_run(16'd10, 16'h1021);
      send(8'h80);
      check_output("tap_sig1", 32'(signature), 32'h0080);
      for (int i = 0; i < 8; i++) send(8'h00);
      check_output("tap_sig9", 32'(signature), 32'h8000);
      send(8'h00);
      check_output("tap_sig10", 32'(signature), 32'h1021);
      finish_run("tap", 1'b1, 16'h1021, 16'd10);

      // Zero patterns: straight to CHECK, signature reloaded to SEED, valid ignored.
      resp_valid = 1'b1;
      resp_data  = 8'hFF;
      start_run(16'd0, 16'h0000);
      resp_valid = 1'b1;
      check_output("zero_busy", 32'(busy), 32'd1);
      check_output("zero_sig", 32'(signature), 32'h0000);
      finish_run("zero", 1'b1, 16'h0000, 16'd0);
      resp_valid = 1'b0;

      // Backpressure gap: 01, 3 idle cycles, 03 -> 0001, 05 -> 0007.
      start_run(16'd3, 16'h0007);
      send(8'h01);
      for (int i = 0; i < 3; i++) begin
         resp_data = 8'h5A;
         tick();
         check_output("gap_sig", 32'(signature), 32'h0001);
         check_output("gap_seen", 32'(patterns_seen), 32'd1);
         check_output("gap_ready", 32'(resp_ready), 32'd1);
      end
      send(8'h03);
      check_output("gap_sig2", 32'(signature), 32'h0001);
      send(8'h05);
      check_output("gap_sig3", 32'(signature), 32'h0007);
      finish_run("gap", 1'b1, 16'h0007, 16'd3);

      // Abort: reset after 1 of 4 responses clears everything at once.
      start_run(16'd4, 16'h0000);
      send(8'h55);
      check_output("abort_sig1", 32'(signature), 32'h0055);
      rst = 1'b1;
      #1;
      check_output("abort_ready", 32'(resp_ready), 32'd0);
      check_output("abort_busy", 32'(busy), 32'd0);
      check_output("abort_sig", 32'(signature), 32'd0);
      check_output("abort_seen", 32'(patterns_seen), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_output("abort_nodone", 32'(done), 32'd0);
      end

      // start held high while busy (including FIN) has no effect on the run.
      start_run(16'd2, 16'h0009);
      start        = 1'b1;
      num_patterns = 16'd5;
      golden_sig   = 16'h0000;
      send(8'h03);
      send(8'h0F);
      check_output("ign_seen", 32'(patterns_seen), 32'd2);
      finish_run("ign", 1'b1, 16'h0009, 16'd2);
      start = 1'b0;
      tick();
      check_output("ign_idle", 32'(busy), 32'd0);

`ifdef C17_RESP_XMASK_EN
      // Mask 0C clears bits 2..3 of 0F, leaving 0003.
      resp_xmask = 8'h0C;
      start_run(16'd1, 16'h0003);
      send(8'h0F);
      check_output("xmask_sig", 32'(signature), 32'h0003);
      finish_run("xmask", 1'b1, 16'h0003, 16'd1);
      resp_xmask = 8'h00;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
